// File: rtl/slt_iter_cmp.sv
// slt_iter_cmp
//   Multi-cycle compare unit for the ALU compare path. Operands are compared
//   CHUNK bits per cycle, most significant chunk first. The first chunk that
//   differs decides the outcome, and later chunks cannot override it.
//   Supported operations: SLT (signed <), SLTU (unsigned <), EQ, SLE (signed <=).
//
// Handshake: a transfer happens on a rising edge where valid && ready are
//   both high. The producer holds its payload steady until that edge. The
//   input side accepts only in IDLE. The output side presents out_valid in
//   DONE and keeps result steady until out_ready is seen.
//
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   in_valid/in_ready, a, b, op    operation request (op: 0 SLT, 1 SLTU, 2 EQ, 3 SLE)
//   out_valid/out_ready, result    1-bit comparison result
//   busy           high while in CMP or DONE
//   dbg_state_o    current FSM state (0 IDLE, 1 CMP, 2 DONE)
module slt_iter_cmp #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             result,
    output logic             busy,
    output logic [1:0]       dbg_state_o
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NCHUNK - 1);

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_chunk
            $error("slt_iter_cmp: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_SLT  = 2'd0,
        OP_SLTU = 2'd1,
        OP_EQ   = 2'd2,
        OP_SLE  = 2'd3
    } op_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              decided_q, decided_d;
    logic              lt_q, lt_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [1:0]        op_q, op_d;
    logic              result_q, result_d;

    // Flipping the sign bit maps two's-complement order onto unsigned order,
    // so a single unsigned chunk comparator serves every operation.
    logic              sign_flip;
    logic [WIDTH-1:0]  a_cmp, b_cmp;
    logic [CHUNK-1:0]  chunk_a, chunk_b;

    assign sign_flip = (op_q == OP_SLT) || (op_q == OP_SLE);
    assign a_cmp     = a_q ^ {sign_flip, {(WIDTH-1){1'b0}}};
    assign b_cmp     = b_q ^ {sign_flip, {(WIDTH-1){1'b0}}};
    assign chunk_a   = a_cmp[idx_q*CHUNK +: CHUNK];
    assign chunk_b   = b_cmp[idx_q*CHUNK +: CHUNK];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            decided_q <= 1'b0;
            lt_q      <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            result_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            decided_q <= decided_d;
            lt_q      <= lt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            result_q  <= result_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        decided_d = decided_q;
        lt_d      = lt_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        result_d  = result_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d       = a;
                    b_d       = b;
                    op_d      = op;
                    idx_d     = IDX_LAST;
                    decided_d = 1'b0;
                    lt_d      = 1'b0;
                    state_d   = S_CMP;
                end
            end
            S_CMP: begin
                if (!decided_q && (chunk_a != chunk_b)) begin
                    decided_d = 1'b1;
                    lt_d      = (chunk_a < chunk_b);
                end
                if (idx_q == '0) begin
                    // The last chunk's verdict is folded in through the _d values.
                    state_d = S_DONE;
                    case (op_q)
                        OP_SLT, OP_SLTU: result_d = lt_d;
                        OP_EQ:           result_d = !decided_d;
                        default:         result_d = lt_d || !decided_d;
                    endcase
                end else begin
                    idx_d = idx_q - IDXW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign busy        = (state_q != S_IDLE);
    assign result      = result_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_slt_iter_cmp.sv
// Directed bench for slt_iter_cmp. Three instances share every input:
// CHUNK=16 (4 compare cycles), CHUNK=64 (1 cycle), CHUNK=8 (8 cycles).
module tb_slt_iter_cmp;

  localparam int W = 64;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          in_valid;
  logic          out_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [1:0]    op;
  logic [2:0]    in_ready_w;
  logic [2:0]    out_valid_w;
  logic [2:0]    result_w;
  logic [2:0]    busy_w;
  logic [1:0]    dbg_w [3];

  slt_iter_cmp #(.WIDTH(W), .CHUNK(16)) u_c16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .a(a), .b(b), .op(op), .out_valid(out_valid_w[0]), .out_ready(out_ready),
    .result(result_w[0]), .busy(busy_w[0]), .dbg_state_o(dbg_w[0])
  );
  slt_iter_cmp #(.WIDTH(W), .CHUNK(64)) u_c64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .a(a), .b(b), .op(op), .out_valid(out_valid_w[1]), .out_ready(out_ready),
    .result(result_w[1]), .busy(busy_w[1]), .dbg_state_o(dbg_w[1])
  );
  slt_iter_cmp #(.WIDTH(W), .CHUNK(8)) u_c8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[2]),
    .a(a), .b(b), .op(op), .out_valid(out_valid_w[2]), .out_ready(out_ready),
    .result(result_w[2]), .busy(busy_w[2]), .dbg_state_o(dbg_w[2])
  );

  localparam logic [1:0] SLT = 2'd0, SLTU = 2'd1, EQ = 2'd2, SLE = 2'd3;
  int lat_exp [3] = '{4, 1, 8};

  // scoreboard
  int   total = 0;
  int   bad   = 0;
  logic exp_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // driver: issue one op to all three instances, then collect latency/result
  task automatic run_op(input string tag, input logic [1:0] o,
                        input logic [63:0] av, input logic [63:0] bv, input logic e);
    int   lat  [3];
    logic res  [3];
    bit   seen [3];
    logic ex;
    for (int k = 0; k < 3; k++) begin
      seen[k] = 1'b0; lat[k] = 0; res[k] = 1'b0;
    end
    exp_q.push_back(e);
    check({tag, "_idle"}, {61'd0, in_ready_w}, 64'd7);
    op = o; a = av; b = bv; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    // operands change after acceptance; results must not care
    in_valid = 1'b0; a = ~av; b = av; op = ~o;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
        if (!seen[k] && out_valid_w[k]) begin
          seen[k] = 1'b1; lat[k] = cyc; res[k] = result_w[k];
        end
      end
      if (seen[0] && seen[1] && seen[2]) break;
    end
    ex = exp_q.pop_front();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s_seen%0d", tag, k), {63'd0, seen[k]}, 64'd1);
      check($sformatf("%s_lat%0d", tag, k), 64'(lat[k]), 64'(lat_exp[k]));
      check($sformatf("%s_res%0d", tag, k), {63'd0, res[k]}, {63'd0, ex});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hits;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; op = SLT;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {61'd0, in_ready_w}, 64'd7);
    check("rst_out_valid", {61'd0, out_valid_w}, 64'd0);
    check("rst_result", {61'd0, result_w}, 64'd0);
    check("rst_busy", {61'd0, busy_w}, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op("t1_slt", SLT, 64'd5, 64'hA, 1'b1);
    run_op("t2_slt_neg", SLT, 64'hFFFF_FFFF_FFFF_FFF6, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1);
    run_op("t2_sltu_neg", SLTU, 64'hFFFF_FFFF_FFFF_FFF6, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1);
    run_op("t2_slt_swap", SLT, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF6, 1'b0);
    run_op("t3_slt_m1", SLT, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
    run_op("t3_sltu_m1", SLTU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);
    run_op("t3_slt_00", SLT, 64'd0, 64'd0, 1'b0);
    run_op("t3_eq_00", EQ, 64'd0, 64'd0, 1'b1);
    run_op("t3_sle_00", SLE, 64'd0, 64'd0, 1'b1);
    run_op("t4_slt_min", SLT, 64'h8000_0000_0000_0000, 64'd1, 1'b1);
    run_op("t4_sltu_min", SLTU, 64'h8000_0000_0000_0000, 64'd1, 1'b0);
    run_op("t4_sltu_b0", SLTU, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF1, 1'b1);
    run_op("t4_eq_b0", EQ, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF1, 1'b0);
    run_op("t4_sle_gt", SLE, 64'd7, 64'd3, 1'b0);
    run_op("t4_sle_lt", SLE, 64'hFFFF_FFFF_FFFF_FFFD, 64'd3, 1'b1);
    run_op("t4_eq_hi", EQ, 64'h0001_0000_0000_0000, 64'd0, 1'b0);

    // backpressure: result must wait in DONE with out_ready low
    op = SLT; a = 64'd5; b = 64'hA; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    hits = 0;
    for (int cyc = 0; cyc < 20 && out_valid_w != 3'b111; cyc++) begin
      @(posedge clk);
      #1;
    end
    check("bp_all_done", {61'd0, out_valid_w}, 64'd7);
    // new request with opposite answer must be ignored while busy
    op = SLT; a = 64'hA; b = 64'd5; in_valid = 1'b1;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid", {61'd0, out_valid_w}, 64'd7);
      check("bp_result", {61'd0, result_w}, 64'd7);
      check("bp_in_ready", {61'd0, in_ready_w}, 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_ov", {61'd0, out_valid_w}, 64'd0);
    check("bp_release_ir", {61'd0, in_ready_w}, 64'd7);
    check("bp_release_st", {62'd0, dbg_w[0]}, 64'd0);

    // reset in the second CMP cycle discards the operation
    op = SLT; a = 64'd3; b = 64'd7; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("mid_busy", {61'd0, busy_w}, 64'd7);
    rst = 1'b1;
    #1;
    check("mid_rst_ir", {61'd0, in_ready_w}, 64'd7);
    check("mid_rst_busy", {61'd0, busy_w}, 64'd0);
    check("mid_rst_res", {61'd0, result_w}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(posedge clk);
      #1;
      if (out_valid_w != 3'b000) hits++;
    end
    check("mid_no_out", 64'(hits), 64'd0);
    run_op("t6_slt_3_7", SLT, 64'd3, 64'd7, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
